hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Replaces pure comparator hazard detection with a per-register load scoreboard and a multiply/divide busy counter, both built from countdown counters.
- Adds age-aware squash of younger scoreboard entries on redirect, a hazard-state FSM, and a saturating stall-event counter.
- Sits beside the ID stage and drives the PC/IFID enables, the control-bubble mux and the pipeline flush lines.

---
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS core: per-register load scoreboard, mult/div
// busy counter, redirect flush with younger-entry squash, and a stall-event counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 2,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Issue_ID,
    input  logic [REG_ADDR_W-1:0] Rs_ID,
    input  logic [REG_ADDR_W-1:0] Rt_ID,
    input  logic                  UsesRs_ID,
    input  logic                  UsesRt_ID,
    input  logic [REG_ADDR_W-1:0] WriteReg_ID,
    input  logic                  RegWrite_ID,
    input  logic                  MemRead_ID,
    input  logic                  MultDiv_ID,
    input  logic                  UsesHiLo_ID,
    input  logic                  Redirect_EX,
    input  logic                  Redirect_MEM,
    output logic                  NotStall_PC,
    output logic                  NotStall_IFID,
    output logic                  MuxControl,
    output logic                  Flush_ID,
    output logic                  Flush_EX,
    output logic                  Flush_MEM,
    output logic                  Busy_MD,
    output logic [1:0]            Hazard_State,
    output logic [CNT_W-1:0]      Stall_Count
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int SB_W     = 3;
    localparam int MD_W     = 6;
    localparam logic [SB_W-1:0] LD_INIT = SB_W'(LOAD_LAT);
    localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LAT);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_STALL   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    logic [NUM_REGS-1:0][SB_W-1:0] r_sb;
    logic [MD_W-1:0]               r_md_cnt;
    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CNT_W-1:0]              r_stall_cnt;

    logic w_redir, w_ld_haz, w_md_haz, w_acc, w_load_wr, w_md_start;
    logic w_stall_nxt, w_stall_cur;

    assign w_redir  = Redirect_EX | Redirect_MEM;
    assign w_ld_haz = Issue_ID &
                      ((UsesRs_ID & (Rs_ID != '0) & (r_sb[Rs_ID] != '0)) |
                       (UsesRt_ID & (Rt_ID != '0) & (r_sb[Rt_ID] != '0)));
    assign w_md_haz = Issue_ID & (UsesHiLo_ID | MultDiv_ID) & (r_md_cnt != '0);
    assign w_acc    = Issue_ID & ~w_redir & ~w_ld_haz & ~w_md_haz;

    assign w_load_wr  = w_acc & MemRead_ID & RegWrite_ID & (WriteReg_ID != '0);
    assign w_md_start = w_acc & MultDiv_ID;

    // An entry still at its issue value was issued last cycle and now sits in EX,
    // younger than a branch resolving in MEM, so a MEM redirect kills it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sb <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_load_wr && (WriteReg_ID == REG_ADDR_W'(r)))
                    r_sb[r] <= LD_INIT;
                else if (Redirect_MEM && (r_sb[r] == LD_INIT))
                    r_sb[r] <= '0;
                else if (r_sb[r] != '0)
                    r_sb[r] <= r_sb[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_md_cnt <= '0;
        else if (w_md_start)
            r_md_cnt <= MD_INIT;
        else if (Redirect_MEM && (r_md_cnt == MD_INIT))
            r_md_cnt <= '0;
        else if (r_md_cnt != '0)
            r_md_cnt <= r_md_cnt - 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = ST_RUN;
        NotStall_PC   = 1'b1;
        NotStall_IFID = 1'b1;
        MuxControl    = 1'b1;
        Flush_ID      = 1'b0;
        Flush_EX      = 1'b0;
        Flush_MEM     = 1'b0;
        if (w_redir) begin
            w_state_nxt = ST_FLUSH;
            MuxControl  = 1'b0;
            Flush_ID    = 1'b1;
            Flush_EX    = 1'b1;
            Flush_MEM   = Redirect_MEM;
        end else if (w_ld_haz || w_md_haz) begin
            w_state_nxt   = w_ld_haz ? ST_LOAD_STALL : ST_MD_STALL;
            NotStall_PC   = 1'b0;
            NotStall_IFID = 1'b0;
            MuxControl    = 1'b0;
        end
    end

    // Load<->MD transitions stay inside the stall group, so they are one event.
    assign w_stall_nxt = (w_state_nxt == ST_LOAD_STALL) || (w_state_nxt == ST_MD_STALL);
    assign w_stall_cur = (r_state == ST_LOAD_STALL) || (r_state == ST_MD_STALL);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_stall_cnt <= '0;
        else if (w_stall_nxt && !w_stall_cur && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign Busy_MD      = (r_md_cnt != '0);
    assign Hazard_State = r_state;
    assign Stall_Count  = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hazard_scoreboard;
    localparam int LL = 2;
    localparam int ML = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Issue_ID, UsesRs_ID, UsesRt_ID, RegWrite_ID, MemRead_ID;
    logic       MultDiv_ID, UsesHiLo_ID, Redirect_EX, Redirect_MEM;
    logic [4:0] Rs_ID, Rt_ID, WriteReg_ID;

    logic        ns_pc, ns_ifid, mux, f_id, f_ex, f_mem, busy;
    logic [1:0]  hst;
    logic [15:0] scnt;
    logic        ns_pc2, ns_ifid2, mux2, f_id2, f_ex2, f_mem2, busy2;
    logic [1:0]  hst2;
    logic [1:0]  scnt2;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(LL), .MD_LAT(ML), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Issue_ID(Issue_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .WriteReg_ID(WriteReg_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MultDiv_ID(MultDiv_ID),
        .UsesHiLo_ID(UsesHiLo_ID), .Redirect_EX(Redirect_EX), .Redirect_MEM(Redirect_MEM),
        .NotStall_PC(ns_pc), .NotStall_IFID(ns_ifid), .MuxControl(mux),
        .Flush_ID(f_id), .Flush_EX(f_ex), .Flush_MEM(f_mem), .Busy_MD(busy),
        .Hazard_State(hst), .Stall_Count(scnt));

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(LL), .MD_LAT(ML), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Issue_ID(Issue_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .WriteReg_ID(WriteReg_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MultDiv_ID(MultDiv_ID),
        .UsesHiLo_ID(UsesHiLo_ID), .Redirect_EX(Redirect_EX), .Redirect_MEM(Redirect_MEM),
        .NotStall_PC(ns_pc2), .NotStall_IFID(ns_ifid2), .MuxControl(mux2),
        .Flush_ID(f_id2), .Flush_EX(f_ex2), .Flush_MEM(f_mem2), .Busy_MD(busy2),
        .Hazard_State(hst2), .Stall_Count(scnt2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a register is unusable until the cycle stamped in ready_at;
    // issue stamps let a MEM redirect cancel whatever issued the cycle before.
    int cyc;
    int ready_at [32];
    int ld_iss   [32];
    int md_free, md_iss;
    int m_state, m_cnt, m_cnt2;

    function automatic logic m_ld();
        return Issue_ID &&
               ((UsesRs_ID && Rs_ID != 0 && cyc < ready_at[Rs_ID]) ||
                (UsesRt_ID && Rt_ID != 0 && cyc < ready_at[Rt_ID]));
    endfunction

    function automatic logic m_md();
        return Issue_ID && (UsesHiLo_ID || MultDiv_ID) && cyc < md_free;
    endfunction

    always @(negedge Clk) begin
        if (Reset) begin
            chk("rst_ns_pc", ns_pc, 1);   chk("rst_mux", mux, 1);
            chk("rst_flush", {f_id, f_ex, f_mem}, 0);
            chk("rst_busy", busy, 0);     chk("rst_state", hst, 0);
            chk("rst_cnt", scnt, 0);      chk("rst_cnt2", scnt2, 0);
            cyc = 0; md_free = 0; md_iss = -100;
            m_state = 0; m_cnt = 0; m_cnt2 = 0;
            for (int r = 0; r < 32; r++) begin
                ready_at[r] = 0;
                ld_iss[r]   = -100;
            end
        end else begin
            logic ld, md, redir, stall, acc;
            ld    = m_ld();
            md    = m_md();
            redir = Redirect_EX || Redirect_MEM;
            stall = !redir && (ld || md);
            acc   = Issue_ID && !redir && !ld && !md;
            chk("ns_pc",   ns_pc,   stall ? 0 : 1);
            chk("ns_ifid", ns_ifid, stall ? 0 : 1);
            chk("mux",     mux,     (stall || redir) ? 0 : 1);
            chk("f_id",    f_id,    redir);
            chk("f_ex",    f_ex,    redir);
            chk("f_mem",   f_mem,   Redirect_MEM);
            chk("busy",    busy,    cyc < md_free);
            chk("state",   hst,     m_state);
            chk("cnt",     scnt,    m_cnt);
            chk("cnt2",    scnt2,   m_cnt2);
            chk("ns_pc2",  ns_pc2,  stall ? 0 : 1);
            chk("state2",  hst2,    m_state);
            chk("busy2",   busy2,   cyc < md_free);
            chk("flush2",  {mux2, f_id2, f_ex2, f_mem2, ns_ifid2},
                {!(stall || redir), redir, redir, Redirect_MEM, !stall});
            if (stall && m_state != 1 && m_state != 2) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3)    m_cnt2++;
            end
            m_state = redir ? 3 : ld ? 1 : md ? 2 : 0;
            if (Redirect_MEM) begin
                for (int r = 0; r < 32; r++)
                    if (ld_iss[r] == cyc - 1) ready_at[r] = 0;
                if (md_iss == cyc - 1) md_free = 0;
            end
            if (acc && MemRead_ID && RegWrite_ID && WriteReg_ID != 0) begin
                ready_at[WriteReg_ID] = cyc + LL + 1;
                ld_iss[WriteReg_ID]   = cyc;
            end
            if (acc && MultDiv_ID) begin
                md_free = cyc + ML + 1;
                md_iss  = cyc;
            end
            cyc++;
        end
    end

    task automatic put(input logic iss, input int rs, input int rt, input logic urs,
                       input logic urt, input int wr, input logic rw, input logic mr,
                       input logic md, input logic hl, input logic rex, input logic rmem);
        Issue_ID = iss; Rs_ID = 5'(rs); Rt_ID = 5'(rt); UsesRs_ID = urs; UsesRt_ID = urt;
        WriteReg_ID = 5'(wr); RegWrite_ID = rw; MemRead_ID = mr; MultDiv_ID = md;
        UsesHiLo_ID = hl; Redirect_EX = rex; Redirect_MEM = rmem;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic nop();          put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lw(input int r); put(1, 0, 0, 0, 0, r, 1, 1, 0, 0, 0, 0); endtask
    task automatic add(input int rs, input int rt);
        put(1, rs, rt, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    endtask
    task automatic mult();         put(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic mflo();         put(1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0); endtask

    initial begin
        Reset = 1'b1;
        nop();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        chk("L_reset_ns", ns_pc, 1);
        chk("L_reset_cnt", scnt, 0);

        // load-use: lw $5 at cycle 0, add $6,$5,$7 stalls cycles 1-2, issues cycle 3
        tick(); lw(5);       chk("L_lw_ns", ns_pc, 1);
        tick(); add(5, 7);   chk("L_c1_ns", ns_pc, 0); chk("L_c1_mux", mux, 0);
                             chk("L_c1_st", hst, 0);
        tick(); add(5, 7);   chk("L_c2_ns", ns_pc, 0); chk("L_c2_st", hst, 1);
                             chk("L_c2_cnt", scnt, 1);
        tick(); add(5, 7);   chk("L_c3_ns", ns_pc, 1); chk("L_c3_st", hst, 1);
        tick(); nop();       chk("L_c4_st", hst, 0);   chk("L_c4_cnt", scnt, 1);

        // $0 and unused-source filtering
        tick(); lw(0);
        tick(); add(0, 0);   chk("L_r0_ns", ns_pc, 1);
        tick(); lw(5);
        tick(); put(1, 1, 5, 1, 0, 6, 1, 0, 0, 0, 0, 0);
                             chk("L_nort_ns", ns_pc, 1);
        tick(); nop(); tick(); nop(); tick(); nop();

        // mult/div busy: mflo stalls cycles 1-4, issues cycle 5
        tick(); mult();
        for (int i = 1; i <= 4; i++) begin
            tick(); mflo();
            chk("L_md_busy", busy, 1); chk("L_md_ns", ns_pc, 0);
        end
        tick(); mflo();      chk("L_md_go", ns_pc, 1); chk("L_md_idle", busy, 0);
                             chk("L_md_st", hst, 2);   chk("L_md_cnt", scnt, 2);
        tick(); mult();
        tick(); mult();      chk("L_mm_ns", ns_pc, 0);
        tick(); nop();       chk("L_mm_cnt", scnt, 3);
        repeat (5) begin tick(); nop(); end

        // MEM redirect squashes the load issued just before it
        tick(); lw(8);
        tick(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                             chk("L_rm_flush", {f_id, f_ex, f_mem}, 7);
                             chk("L_rm_mux", mux, 0); chk("L_rm_ns", ns_pc, 1);
        tick(); add(8, 0);   chk("L_rm_add", ns_pc, 1); chk("L_rm_st", hst, 3);
        tick(); nop();

        // EX redirect keeps the scoreboard entry
        tick(); lw(8);
        tick(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                             chk("L_re_flush", {f_id, f_ex, f_mem}, 6);
        tick(); add(8, 0);   chk("L_re_add", ns_pc, 0); chk("L_re_st", hst, 3);
        tick(); add(8, 0);   chk("L_re_go", ns_pc, 1);  chk("L_re_cnt", scnt, 4);
        tick(); nop();

        // redirect outranks a load hazard and is not a stall event
        tick(); lw(9);
        tick(); put(1, 9, 0, 1, 0, 6, 1, 0, 0, 0, 1, 0);
                             chk("L_pr_ns", ns_pc, 1); chk("L_pr_fid", f_id, 1);
        tick(); add(9, 0);   chk("L_pr_st", hst, 3);   chk("L_pr_cnt", scnt, 4);
                             chk("L_pr_ns2", ns_pc, 0);
        tick(); nop();       chk("L_sat_cnt", scnt, 5); chk("L_sat_cnt2", scnt2, 3);
        tick(); nop();

        // reset in the middle of a load stall
        tick(); lw(5);
        tick(); add(5, 0);   chk("L_ms_ns", ns_pc, 0);
        Reset = 1'b1; #1;
        chk("L_ms_rst_ns", ns_pc, 1); chk("L_ms_rst_st", hst, 0);
        chk("L_ms_rst_cnt", scnt, 0);
        tick(); #1 Reset = 1'b0;
        tick(); add(5, 0);   chk("L_post_rst", ns_pc, 1);
        tick(); nop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
